// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/load-store stages, the arbiter and the memory model.
// master = arbiter side, slave = pipeline/memory environment side.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_valid;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              stall;
    logic              err;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_rdata, i_valid, d_rdata, d_valid,
        output mem_req, mem_we, mem_addr, mem_wdata, stall, err
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_rdata, i_valid, d_rdata, d_valid,
        input  mem_req, mem_we, mem_addr, mem_wdata, stall, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (I) and load/store (D) with D-priority and bounded I starvation.
// Define ARB_TIMEOUT_EN to add a watchdog that abandons transactions stuck without mem_ready.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned FAIR_MAX = 4,
    parameter int unsigned TIMEOUT  = 64
) (
    input logic                 clk,
    input logic                 rst,
    mem_port_arbiter_if.master  bus
);
    localparam int unsigned FAIR_W = 4;

    if (FAIR_MAX < 1 || FAIR_MAX > 15 || TIMEOUT < 1) begin : g_bad_param
        $error("mem_port_arbiter: FAIR_MAX must be 1..15 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

    state_e              state_q;
    logic [FAIR_W-1:0]   fair_cnt_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W-1:0]   i_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;
    logic                i_valid_q;
    logic                d_valid_q;
    logic                err_q;

    logic                timeout;
    logic                complete;
    logic [DATA_W-1:0]   rsp_data;
    logic                grant_d;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [WD_W-1:0] wdog_q;

    assign timeout = (state_q != IDLE) && !bus.mem_ready && (wdog_q == WD_W'(TIMEOUT - 1));

    // Watchdog: zero in IDLE so every grant starts from a fresh count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_q == IDLE || complete) wdog_q <= '0;
            else                             wdog_q <= wdog_q + WD_W'(1);
            if (timeout) err_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err_q   = 1'b0;
`endif

    assign complete = bus.mem_ready || timeout;
    assign rsp_data = bus.mem_ready ? bus.mem_rdata : DATA_W'(32'hDEAD_BEEF);
    assign grant_d  = bus.d_req && (!bus.i_req || (fair_cnt_q < FAIR_W'(FAIR_MAX)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fair_cnt_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_valid_q   <= 1'b0;
            d_valid_q   <= 1'b0;
        end else begin
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        state_q     <= BUSY_D;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.d_we;
                        mem_addr_q  <= bus.d_addr;
                        mem_wdata_q <= bus.d_wdata;
                        // Count D grants only while fetch is actually kept waiting
                        if (!bus.i_req)                           fair_cnt_q <= '0;
                        else if (fair_cnt_q < FAIR_W'(FAIR_MAX))  fair_cnt_q <= fair_cnt_q + FAIR_W'(1);
                    end else if (bus.i_req) begin
                        state_q    <= BUSY_I;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= bus.i_addr;
                        fair_cnt_q <= '0;
                    end
                end
                BUSY_I: begin
                    if (complete) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        i_rdata_q <= rsp_data;
                        i_valid_q <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (complete) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        d_rdata_q <= rsp_data;
                        d_valid_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_valid   = i_valid_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.err       = err_q;
    assign bus.stall     = (bus.i_req && !i_valid_q) || (bus.d_req && !d_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (FAIR_MAX=4, TIMEOUT=8).
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_mis = 0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FAIR_MAX(4), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
        bus.mem_rdata = 0; bus.mem_ready = 0;
        tick(); tick();
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_mis++; $display("FAIL rst_mem_req: got %b want 0", bus.mem_req); end
        n_cmp++; if (bus.mem_addr !== 32'h0) begin n_mis++; $display("FAIL rst_mem_addr: got %h want 0", bus.mem_addr); end
        n_cmp++; if ({bus.i_valid, bus.d_valid, bus.err, bus.mem_we} !== 4'b0) begin n_mis++; $display("FAIL rst_flags: got %b want 0000", {bus.i_valid, bus.d_valid, bus.err, bus.mem_we}); end
        n_cmp++; if ({bus.i_rdata, bus.d_rdata} !== 64'h0) begin n_mis++; $display("FAIL rst_rdata: got %h want 0", {bus.i_rdata, bus.d_rdata}); end
        rst = 1'b0;
        tick();
        n_cmp++; if (bus.stall !== 1'b0) begin n_mis++; $display("FAIL rst_stall: got %b want 0", bus.stall); end
    endtask

    task automatic test_fetch_single();
        bus.i_req = 1; bus.i_addr = 32'h0000_0010;
        #1;
        n_cmp++; if (bus.stall !== 1'b1) begin n_mis++; $display("FAIL t1_stall_c0: got %b want 1", bus.stall); end
        tick();
        n_cmp++; if ({bus.mem_req, bus.mem_we} !== 2'b10) begin n_mis++; $display("FAIL t1_mem_req_we: got %b want 10", {bus.mem_req, bus.mem_we}); end
        n_cmp++; if (bus.mem_addr !== 32'h10) begin n_mis++; $display("FAIL t1_mem_addr: got %h want 00000010", bus.mem_addr); end
        n_cmp++; if (bus.stall !== 1'b1 || bus.i_valid !== 1'b0) begin n_mis++; $display("FAIL t1_c1: got stall=%b i_valid=%b want 1/0", bus.stall, bus.i_valid); end
        bus.mem_ready = 1; bus.mem_rdata = 32'h3402_0005;
        tick();
        n_cmp++; if (bus.i_valid !== 1'b1) begin n_mis++; $display("FAIL t1_i_valid: got %b want 1", bus.i_valid); end
        n_cmp++; if (bus.i_rdata !== 32'h3402_0005) begin n_mis++; $display("FAIL t1_i_rdata: got %h want 34020005", bus.i_rdata); end
        n_cmp++; if (bus.stall !== 1'b0 || bus.mem_req !== 1'b0) begin n_mis++; $display("FAIL t1_c2: got stall=%b mem_req=%b want 0/0", bus.stall, bus.mem_req); end
        bus.i_req = 0; bus.mem_ready = 0; bus.mem_rdata = 32'h0;
        tick();
        n_cmp++; if ({bus.i_valid, bus.mem_req} !== 2'b00 || bus.i_rdata !== 32'h3402_0005) begin n_mis++; $display("FAIL t1_hold: got v=%b req=%b rdata=%h want 0/0/34020005", bus.i_valid, bus.mem_req, bus.i_rdata); end
    endtask

    task automatic test_simultaneous();
        bus.i_req = 1; bus.i_addr = 32'h20;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h40; bus.d_wdata = 32'h1234;
        tick();
        n_cmp++; if ({bus.mem_req, bus.mem_we} !== 2'b11 || bus.mem_addr !== 32'h40 || bus.mem_wdata !== 32'h1234) begin n_mis++; $display("FAIL t2_d_first: got req=%b we=%b addr=%h wdata=%h want 1/1/40/1234", bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        bus.mem_ready = 1;
        tick();
        n_cmp++; if ({bus.d_valid, bus.i_valid} !== 2'b10) begin n_mis++; $display("FAIL t2_d_valid: got d=%b i=%b want 1/0", bus.d_valid, bus.i_valid); end
        bus.d_req = 0; bus.d_we = 0; bus.mem_ready = 0;
        tick();
        n_cmp++; if ({bus.mem_req, bus.mem_we} !== 2'b10 || bus.mem_addr !== 32'h20) begin n_mis++; $display("FAIL t2_i_second: got req=%b we=%b addr=%h want 1/0/20", bus.mem_req, bus.mem_we, bus.mem_addr); end
        n_cmp++; if (bus.stall !== 1'b1) begin n_mis++; $display("FAIL t2_stall: got %b want 1", bus.stall); end
        bus.mem_ready = 1; bus.mem_rdata = 32'hAAAA_5555;
        tick();
        n_cmp++; if ({bus.i_valid, bus.d_valid} !== 2'b10 || bus.i_rdata !== 32'hAAAA_5555) begin n_mis++; $display("FAIL t2_i_valid: got i=%b d=%b rdata=%h want 1/0/aaaa5555", bus.i_valid, bus.d_valid, bus.i_rdata); end
        bus.i_req = 0; bus.mem_ready = 0;
        tick();
    endtask

    task automatic test_fairness();
        logic [5:0] exp_d = 6'b101111;  // grant k is D when bit k set: D,D,D,D,I,D
        bus.i_req = 1; bus.i_addr = 32'h200;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== (exp_d[k] ? 32'h100 : 32'h200)) begin n_mis++; $display("FAIL t3_grant%0d: got req=%b addr=%h want 1/%h", k, bus.mem_req, bus.mem_addr, exp_d[k] ? 32'h100 : 32'h200); end
            bus.mem_ready = 1; bus.mem_rdata = 32'h1000 + k;
            tick();
            n_cmp++; if ({bus.d_valid, bus.i_valid} !== (exp_d[k] ? 2'b10 : 2'b01)) begin n_mis++; $display("FAIL t3_valid%0d: got d=%b i=%b want %b", k, bus.d_valid, bus.i_valid, exp_d[k] ? 2'b10 : 2'b01); end
            bus.mem_ready = 0;
        end
        bus.i_req = 0; bus.d_req = 0;
        tick();
    endtask

    task automatic test_slow_load();
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h80;
        tick();
        bus.d_addr = 32'h84;
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h80 || bus.d_valid !== 1'b0) begin n_mis++; $display("FAIL t4_wait%0d: got req=%b addr=%h dv=%b want 1/80/0", k, bus.mem_req, bus.mem_addr, bus.d_valid); end
            tick();
        end
        bus.mem_ready = 1; bus.mem_rdata = 32'hCAFE_F00D;
        tick();
        n_cmp++; if (bus.d_valid !== 1'b1 || bus.d_rdata !== 32'hCAFE_F00D) begin n_mis++; $display("FAIL t4_done: got dv=%b rdata=%h want 1/cafef00d", bus.d_valid, bus.d_rdata); end
        bus.d_req = 0; bus.mem_rdata = 32'h5A5A_5A5A;
        tick();
        n_cmp++; if (bus.d_valid !== 1'b0 || bus.d_rdata !== 32'hCAFE_F00D || bus.mem_req !== 1'b0) begin n_mis++; $display("FAIL t4_after: got dv=%b rdata=%h req=%b want 0/cafef00d/0", bus.d_valid, bus.d_rdata, bus.mem_req); end
        tick();
        n_cmp++; if ({bus.i_valid, bus.d_valid, bus.err} !== 3'b000) begin n_mis++; $display("FAIL t4_stray_ready: got %b want 000", {bus.i_valid, bus.d_valid, bus.err}); end
        bus.mem_ready = 0;
    endtask

    task automatic test_reset_mid();
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h60;
        tick();
        n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h60) begin n_mis++; $display("FAIL t5_busy: got req=%b addr=%h want 1/60", bus.mem_req, bus.mem_addr); end
        #2 rst = 1'b1; bus.d_req = 0;
        #1;
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_mis++; $display("FAIL t5_async: got %b want 0", bus.mem_req); end
        bus.mem_ready = 1;
        tick();
        n_cmp++; if (bus.d_valid !== 1'b0 || bus.i_rdata !== 32'h0) begin n_mis++; $display("FAIL t5_no_valid: got dv=%b i_rdata=%h want 0/0", bus.d_valid, bus.i_rdata); end
        rst = 1'b0; bus.mem_ready = 0;
        bus.i_req = 1; bus.i_addr = 32'h30;
        tick();
        n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h30 || bus.mem_we !== 1'b0) begin n_mis++; $display("FAIL t5_regrant: got req=%b addr=%h we=%b want 1/30/0", bus.mem_req, bus.mem_addr, bus.mem_we); end
        bus.mem_ready = 1; bus.mem_rdata = 32'h0BAD_CAFE;
        tick();
        n_cmp++; if (bus.i_valid !== 1'b1 || bus.i_rdata !== 32'h0BAD_CAFE) begin n_mis++; $display("FAIL t5_fetch: got iv=%b rdata=%h want 1/0badcafe", bus.i_valid, bus.i_rdata); end
        bus.i_req = 0; bus.mem_ready = 0;
        tick();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        bus.i_req = 1; bus.i_addr = 32'h44;
        tick();
        for (int k = 1; k < 8; k++) begin
            n_cmp++; if (bus.mem_req !== 1'b1 || bus.i_valid !== 1'b0 || bus.err !== 1'b0) begin n_mis++; $display("FAIL t6_wait%0d: got req=%b iv=%b err=%b want 1/0/0", k, bus.mem_req, bus.i_valid, bus.err); end
            tick();
        end
        n_cmp++; if (bus.mem_req !== 1'b1 || bus.err !== 1'b0) begin n_mis++; $display("FAIL t6_busy8: got req=%b err=%b want 1/0", bus.mem_req, bus.err); end
        tick();
        n_cmp++; if (bus.i_valid !== 1'b1 || bus.i_rdata !== 32'hDEAD_BEEF || bus.err !== 1'b1 || bus.mem_req !== 1'b0) begin n_mis++; $display("FAIL t6_expire: got iv=%b rdata=%h err=%b req=%b want 1/deadbeef/1/0", bus.i_valid, bus.i_rdata, bus.err, bus.mem_req); end
        bus.i_req = 0;
        tick();
        n_cmp++; if (bus.err !== 1'b1 || bus.i_valid !== 1'b0 || bus.mem_req !== 1'b0) begin n_mis++; $display("FAIL t6_sticky: got err=%b iv=%b req=%b want 1/0/0", bus.err, bus.i_valid, bus.mem_req); end
    endtask
`endif

    initial begin
        test_reset();
        test_fetch_single();
        test_simultaneous();
        test_fairness();
        test_slow_load();
        test_reset_mid();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
